dbus_sram_responder: RTL

//  Responder end of the data bus: the core issues dreq and waits for dresp; this block answers.

---
 rtl/dbus_sram_responder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dbus_sram_responder.sv
// Data-bus responder backed by a word-addressed 64-bit SRAM.
// Serves one load/store at a time, answering LATENCY cycles after accept (stallable via hold).

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

module dbus_sram_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  dbus_req_t   dreq,
  output dbus_resp_t  dresp,
  input  logic        hold,
  output logic        busy,
  output logic [31:0] n_reads,
  output logic [31:0] n_writes
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_idx;
  logic [7:0]  r_strobe;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [63:0] r_mem [DEPTH];

  logic [63:0] w_off;
  logic [AW-1:0] w_req_idx;
  logic [AW-1:0] w_rd_idx;
  logic        w_accept;
  logic        w_enter_resp;
  logic        w_unused;

  // Index wraps modulo DEPTH; the byte offset within the word is ignored.
  assign w_off     = dreq.addr - BASE;
  assign w_req_idx = w_off[AW+2:3];
  assign w_unused  = ^{w_off[63:AW+3], w_off[2:0], dreq.size};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dreq.valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!hold && r_cnt <= CW'(1)) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_enter_resp = (w_state_nxt == S_RESP);
  assign w_rd_idx     = (r_state == S_IDLE) ? w_req_idx : r_idx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= '0;
      n_reads  <= '0;
      n_writes <= '0;
    end else begin
      if (w_accept)                       r_cnt <= CW'(LATENCY - 1);
      else if (r_state == S_WAIT && !hold) r_cnt <= r_cnt - 1'b1;
      if (r_state == S_RESP) begin
        if (r_strobe == 8'h00) n_reads  <= n_reads + 32'd1;
        else                   n_writes <= n_writes + 32'd1;
      end
    end
  end

  // Request payload and SRAM are data: never reset, so contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_idx    <= w_req_idx;
      r_strobe <= dreq.strobe;
      r_wdata  <= dreq.data;
    end
    if (w_enter_resp) r_rdata <= r_mem[w_rd_idx];
    if (r_state == S_RESP) begin
      for (int i = 0; i < 8; i++) begin
        if (r_strobe[i]) r_mem[r_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    dresp         = '0;
    dresp.addr_ok = w_accept & ~reset;
    dresp.data_ok = (r_state == S_RESP);
    dresp.data    = (r_state == S_RESP && r_strobe == 8'h00) ? r_rdata : 64'h0;
  end

  assign busy = (r_state != S_IDLE);

endmodule
